// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: operand/result valid-ready bundle for the pipelined CLA adder
interface cla_adder_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             p_all;
  logic             g_all;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, p_all, g_all
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, p_all, g_all
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined group carry-lookahead add/sub with valid/ready flow control
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic           clk,
  input logic           rst_n,
  cla_adder_pipe_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  logic adv;
  logic [WIDTH-1:0] b_eff;
  logic v1, c0_1;
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0] gp, gg;
  logic [NG:0] gc;
  logic wg, t2, acc2;
  logic v2, pa2, wg2;
  logic [WIDTH-1:0] p2, g2;
  logic [NG:0] gc2;
  logic [WIDTH-1:0] c;
  logic t3, acc3;
  logic v3, co3, pa3, wg3;
  logic [WIDTH-1:0] p3, c3;
  logic ov_q, cout_q, ovf_q, zero_q, pa_q, ga_q;
  logic [WIDTH-1:0] sum_q, sum_n;
  // one global advance: every stage shifts together or holds together
  assign adv          = !ov_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1   <= 1'b0;
      c0_1 <= 1'b0;
      p1   <= '0;
      g1   <= '0;
    end else if (adv) begin
      v1   <= bus.in_valid;
      c0_1 <= bus.sub | bus.cin;
      p1   <= bus.a ^ b_eff;
      g1   <= bus.a & b_eff;
    end
  // group P/G, then group carry-ins expanded as a flat lookahead from c0
  always_comb begin
    gp   = '0;
    gg   = '0;
    gc   = '0;
    wg   = 1'b0;
    t2   = 1'b0;
    acc2 = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p1[j*GROUP +: GROUP];
      acc2  = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        t2 = g1[j*GROUP+i];
        for (int k = 0; k < GROUP; k++) if (k > i) t2 = t2 & p1[j*GROUP+k];
        acc2 = acc2 | t2;
      end
      gg[j] = acc2;
    end
    for (int j = 0; j <= NG; j++) begin
      acc2 = c0_1;
      for (int k = 0; k < NG; k++) if (k < j) acc2 = acc2 & gp[k];
      for (int i = 0; i < NG; i++) if (i < j) begin
        t2 = gg[i];
        for (int k = 0; k < NG; k++) if (k > i && k < j) t2 = t2 & gp[k];
        acc2 = acc2 | t2;
      end
      gc[j] = acc2;
    end
    for (int i = 0; i < NG; i++) begin
      t2 = gg[i];
      for (int k = 0; k < NG; k++) if (k > i) t2 = t2 & gp[k];
      wg = wg | t2;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2  <= 1'b0;
      p2  <= '0;
      g2  <= '0;
      gc2 <= '0;
      pa2 <= 1'b0;
      wg2 <= 1'b0;
    end else if (adv) begin
      v2  <= v1;
      p2  <= p1;
      g2  <= g1;
      gc2 <= gc;
      pa2 <= &gp;
      wg2 <= wg;
    end
  // per-bit carry into each position, looked ahead from its group carry-in
  always_comb begin
    c    = '0;
    t3   = 1'b0;
    acc3 = 1'b0;
    for (int j = 0; j < NG; j++)
      for (int i = 0; i < GROUP; i++) begin
        acc3 = gc2[j];
        for (int k = 0; k < GROUP; k++) if (k < i) acc3 = acc3 & p2[j*GROUP+k];
        for (int m = 0; m < GROUP; m++) if (m < i) begin
          t3 = g2[j*GROUP+m];
          for (int k = 0; k < GROUP; k++) if (k > m && k < i) t3 = t3 & p2[j*GROUP+k];
          acc3 = acc3 | t3;
        end
        c[j*GROUP+i] = acc3;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v3  <= 1'b0;
      p3  <= '0;
      c3  <= '0;
      co3 <= 1'b0;
      pa3 <= 1'b0;
      wg3 <= 1'b0;
    end else if (adv) begin
      v3  <= v2;
      p3  <= p2;
      c3  <= c;
      co3 <= gc2[NG];
      pa3 <= pa2;
      wg3 <= wg2;
    end
  assign sum_n = p3 ^ c3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      pa_q   <= 1'b0;
      ga_q   <= 1'b0;
    end else if (adv) begin
      ov_q   <= v3;
      sum_q  <= sum_n;
      cout_q <= co3;
      ovf_q  <= co3 ^ c3[WIDTH-1];
      zero_q <= ~|sum_n;
      pa_q   <= pa3;
      ga_q   <= wg3;
    end
  assign bus.out_valid = ov_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.p_all     = pa_q;
  assign bus.g_all     = ga_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed and scoreboard checks of cla_adder_pipe at 32/4, 8/2 and 16/8
module tb_cla_adder_pipe;
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        p_all;
    logic        g_all;
  } res_t;
  localparam int NR = 10000;
  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cla_adder_pipe_if #(.WIDTH(32)) bus0();
  cla_adder_pipe_if #(.WIDTH(8))  bus1();
  cla_adder_pipe_if #(.WIDTH(16)) bus2();
  cla_adder_pipe #(.WIDTH(32), .GROUP(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cla_adder_pipe #(.WIDTH(8),  .GROUP(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cla_adder_pipe #(.WIDTH(16), .GROUP(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic res_t mk(input logic [63:0] s, input logic co, v, z, pa, ga);
    res_t r;
    r.sum = s; r.cout = co; r.ovf = v; r.zero = z; r.p_all = pa; r.g_all = ga;
    return r;
  endfunction
  function automatic res_t get0();
    return mk(64'(bus0.sum), bus0.cout, bus0.ovf, bus0.zero, bus0.p_all, bus0.g_all);
  endfunction
  function automatic res_t get1();
    return mk(64'(bus1.sum), bus1.cout, bus1.ovf, bus1.zero, bus1.p_all, bus1.g_all);
  endfunction
  function automatic res_t get2();
    return mk(64'(bus2.sum), bus2.cout, bus2.ovf, bus2.zero, bus2.p_all, bus2.g_all);
  endfunction
  // arithmetic reference, independent of any propagate/generate structure
  function automatic res_t model(input logic [63:0] a, b, input logic cin, sub, input int w);
    logic [64:0] m, h, bb, full, lo, gw;
    logic c0;
    res_t r;
    m    = (65'd1 << w) - 65'd1;
    h    = (65'd1 << (w - 1)) - 65'd1;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    c0   = sub | cin;
    full = {1'b0, a} + bb + 65'(c0);
    lo   = ({1'b0, a} & h) + (bb & h) + 65'(c0);
    gw   = {1'b0, a} + bb;
    r.sum   = full[63:0] & m[63:0];
    r.cout  = full[w];
    r.ovf   = full[w] ^ lo[w-1];
    r.zero  = (r.sum == 64'd0);
    r.p_all = ((({1'b0, a} ^ bb) & m) == m);
    r.g_all = gw[w];
    return r;
  endfunction
  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic op32(input logic [31:0] a, b, input logic cin, sub, output res_t r, output int lat);
    bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
    bus0.out_ready = 1'b1; bus0.in_valid = 1'b1;
    @(posedge clk); #1 bus0.in_valid = 1'b0;
    lat = -1; r = '0;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) begin lat = n; r = get0(); end
    end
  endtask

  task automatic test_reset();
    bus0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (get0() !== mk(64'd0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_outputs got=%h exp=0", get0()); end
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus0.out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready); end
    checks++; if ({bus0.out_valid, bus1.out_valid, bus2.out_valid} !== 3'b000) begin errors++; $display("FAIL reset_valid_after got=%b exp=000", {bus0.out_valid, bus1.out_valid, bus2.out_valid}); end
    bus0.out_ready = 1'b1;
  endtask

  task automatic test_carry_chain();
    res_t r; int lat;
    op32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, r, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency got=%0d exp=3", lat); end
    checks++; if (r !== mk(64'h0, 1, 0, 1, 0, 1)) begin errors++; $display("FAIL carry_chain got=%h exp=%h", r, mk(64'h0, 1, 0, 1, 0, 1)); end
  endtask

  task automatic test_alternating();
    res_t r; int lat;
    op32(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, r, lat);
    checks++; if (r !== mk(64'h0, 1, 0, 1, 1, 0)) begin errors++; $display("FAIL alt_cin1 got=%h exp=%h", r, mk(64'h0, 1, 0, 1, 1, 0)); end
    op32(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, r, lat);
    checks++; if (r !== mk(64'hFFFFFFFF, 0, 0, 0, 1, 0)) begin errors++; $display("FAIL alt_cin0 got=%h exp=%h", r, mk(64'hFFFFFFFF, 0, 0, 0, 1, 0)); end
  endtask

  task automatic test_sub();
    res_t r; int lat;
    op32(32'd5, 32'd7, 1'b1, 1'b1, r, lat);
    checks++; if (r !== mk(64'hFFFFFFFE, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL sub_cin1 got=%h exp=%h", r, mk(64'hFFFFFFFE, 0, 0, 0, 0, 0)); end
    op32(32'd5, 32'd7, 1'b0, 1'b1, r, lat);
    checks++; if (r !== mk(64'hFFFFFFFE, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL sub_cin0 got=%h exp=%h", r, mk(64'hFFFFFFFE, 0, 0, 0, 0, 0)); end
    op32(32'd9, 32'd9, 1'b0, 1'b1, r, lat);
    checks++; if (r !== mk(64'h0, 1, 0, 1, 1, 0)) begin errors++; $display("FAIL sub_equal got=%h exp=%h", r, mk(64'h0, 1, 0, 1, 1, 0)); end
  endtask

  task automatic test_overflow();
    res_t r; int lat;
    op32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, r, lat);
    checks++; if (r !== mk(64'h80000000, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL ovf_add got=%h exp=%h", r, mk(64'h80000000, 0, 1, 0, 0, 0)); end
  endtask

  task automatic test_bubble();
    logic [7:0] ov;
    logic [31:0] s3, s5;
    ov = '0; s3 = '0; s5 = '0;
    bus0.out_ready = 1'b1; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.b = 32'd1;
    for (int c = 0; c < 8; c++) begin
      bus0.in_valid = (c == 0 || c == 2);
      bus0.a = 32'(c);
      @(posedge clk); #1;
      ov[c] = bus0.out_valid;
      if (c == 3) s3 = bus0.sum;
      if (c == 5) s5 = bus0.sum;
    end
    bus0.in_valid = 1'b0;
    checks++; if (ov !== 8'b0010_1000) begin errors++; $display("FAIL bubble_slots got=%b exp=00101000", ov); end
    checks++; if ({s3, s5} !== {32'd1, 32'd3}) begin errors++; $display("FAIL bubble_data got=%h,%h exp=1,3", s3, s5); end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, hold = 0, first = -1;
    bit fi, fo;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus0.in_valid = (sent < 5);
      bus0.a = 32'h1000 + 32'(sent); bus0.b = 32'(sent); bus0.cin = 1'b0; bus0.sub = 1'b0;
      bus0.out_ready = !(bus0.out_valid && hold < 4);
      #2;
      fi = bus0.in_valid && bus0.in_ready;
      fo = bus0.out_valid && bus0.out_ready;
      if (bus0.out_valid && !bus0.out_ready) begin
        hold++;
        checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", bus0.in_ready); end
        checks++; if (bus0.sum !== 32'h1000) begin errors++; $display("FAIL stall_hold got=%h exp=00001000", bus0.sum); end
      end
      if (fo) begin
        if (first < 0) first = cyc;
        checks++; if (bus0.sum !== 32'h1000 + 32'(2 * got) || cyc !== first + got) begin
          errors++; $display("FAIL stall_drain%0d got=%h@%0d exp=%h@%0d", got, bus0.sum, cyc, 32'h1000 + 32'(2 * got), first + got);
        end
        got++;
      end
      if (fi) sent++;
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    checks++; if (got !== 5 || hold !== 4) begin errors++; $display("FAIL stall_count got=%0d/%0d exp=5/4", got, hold); end
    @(posedge clk); #1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got=%b exp=0", bus0.out_valid); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus0.out_ready = 1'b1; bus0.b = 32'd0; bus0.cin = 1'b0; bus0.sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = 1'b1; bus0.a = 32'(i + 1);
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got=%b exp=1", bus0.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus0.out_valid, bus0.sum} !== 33'd0) begin errors++; $display("FAIL mid_reset got=%b/%h exp=0/0", bus0.out_valid, bus0.sum); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_flushed got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    res_t q1[$], q2[$];
    int sent1 = 0, sent2 = 0, got1 = 0, got2 = 0, cyc = 0;
    bit f1i, f1o, f2i, f2o;
    while ((got1 < NR || got2 < NR) && cyc < 60000) begin
      bus1.in_valid = (sent1 < NR) && ($urandom_range(3) != 0);
      bus1.a = 8'(pick(8)); bus1.b = 8'(pick(8));
      bus1.cin = 1'($urandom_range(1)); bus1.sub = 1'($urandom_range(1));
      bus1.out_ready = ($urandom_range(3) != 0);
      bus2.in_valid = (sent2 < NR) && ($urandom_range(3) != 0);
      bus2.a = 16'(pick(16)); bus2.b = 16'(pick(16));
      bus2.cin = 1'($urandom_range(1)); bus2.sub = 1'($urandom_range(1));
      bus2.out_ready = ($urandom_range(3) != 0);
      #2;
      f1i = bus1.in_valid && bus1.in_ready; f1o = bus1.out_valid && bus1.out_ready;
      f2i = bus2.in_valid && bus2.in_ready; f2o = bus2.out_valid && bus2.out_ready;
      if (f1o) begin
        checks++;
        if (q1.size() == 0 || get1() !== q1[0]) begin errors++; $display("FAIL rand8 op%0d got=%h exp=%h", got1, get1(), q1.size() ? q1[0] : '0); end
        if (q1.size() != 0) void'(q1.pop_front());
        got1++;
      end
      if (f2o) begin
        checks++;
        if (q2.size() == 0 || get2() !== q2[0]) begin errors++; $display("FAIL rand16 op%0d got=%h exp=%h", got2, get2(), q2.size() ? q2[0] : '0); end
        if (q2.size() != 0) void'(q2.pop_front());
        got2++;
      end
      if (f1i) begin q1.push_back(model(64'(bus1.a), 64'(bus1.b), bus1.cin, bus1.sub, 8)); sent1++; end
      if (f2i) begin q2.push_back(model(64'(bus2.a), 64'(bus2.b), bus2.cin, bus2.sub, 16)); sent2++; end
      @(posedge clk); #1;
      cyc++;
    end
    bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    checks++; if (got1 != NR || got2 != NR) begin errors++; $display("FAIL rand_drain got=%0d/%0d exp=%0d", got1, got2, NR); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;
    test_reset();
    test_carry_chain();
    test_alternating();
    test_sub();
    test_overflow();
    test_bubble();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
